fp_reg_file: RTL and testbench
==============================

# fp_reg_file

Floating-point register file and issue scoreboard for the CPU core's F extension. Holds the 32 architectural registers f0–f31 and supplies the three FPU operands (DATA1/DATA2/DATA3, including the FMADD-family rs3 operand) through combinational read ports with same-cycle writeback bypass. A per-register pending bit tracks instructions whose FPU result has not yet been written back, and generates a stall for RAW and WAW hazards. Sits between decode and the FPU; the writeback stage drives its write port.

## Interface
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; the file has 2**ADDR_WIDTH entries.

- CLK  in  1  core clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READ_ADDR1 / READ_ADDR2 / READ_ADDR3  in  ADDR_WIDTH  rs1/rs2/rs3 indices.
- READ_DATA1 / READ_DATA2 / READ_DATA3  out  DATA_WIDTH  operands to FPU DATA1/DATA2/DATA3.
- WRITE_ENABLE  in  1  writeback strobe.
- WRITE_ADDR  in  ADDR_WIDTH  writeback destination.
- WRITE_DATA  in  DATA_WIDTH  writeback value (FPU RESULT or FLW data).
- ISSUE_VALID  in  1  decode presents an F instruction this cycle.
- ISSUE_DEST  in  ADDR_WIDTH  its FP destination.
- ISSUE_WRITES  in  1  instruction writes an FP register (0 for FEQ/FLT/FLE/FCVT.W.S/FSW).
- RS1_USED / RS2_USED / RS3_USED  in  1  per-source usage flags.
- FLUSH  in  1  pipeline flush; discards all in-flight destinations.
- HAZARD  out  1  stall request to decode (combinational).
- PENDING  out  2**ADDR_WIDTH  pending-bit vector, for debug and verification.

## Operation
- Storage: 32 × DATA_WIDTH registers. All entries are writable (f0 is not hardwired to zero).
- Read: READ_DATAn = WRITE_DATA if WRITE_ENABLE && WRITE_ADDR == READ_ADDRn; otherwise regs[READ_ADDRn]. All three ports are independent; identical addresses are legal.
- Write: at the rising edge, regs[WRITE_ADDR] ← WRITE_DATA when WRITE_ENABLE.
- Source hazard n (n = 1..3) = RSn_USED && pending[READ_ADDRn] && !(WRITE_ENABLE && WRITE_ADDR == READ_ADDRn).
- Destination hazard = ISSUE_WRITES && pending[ISSUE_DEST] && !(WRITE_ENABLE && WRITE_ADDR == ISSUE_DEST).
- HAZARD = ISSUE_VALID && !FLUSH && (any source hazard || destination hazard).
- Accepted issue = ISSUE_VALID && !HAZARD && !FLUSH && ISSUE_WRITES.
- Pending update at each edge, highest priority first:
  - FLUSH: all bits ← 0.
  - Accepted issue to address A: pending[A] ← 1. This takes precedence over a same-address writeback in the same cycle.
  - WRITE_ENABLE to address B: pending[B] ← 0.
  - Otherwise the bit holds.
- Writeback to a register that is not pending is legal and only updates data.
- FLUSH does not block or undo a same-cycle writeback; the register data is still written.

## Timing
- Reset (async): all regs ← 0, all pending ← 0. Consequently READ_DATAn = 0, PENDING = 0, HAZARD = 0 while no writeback is presented.
- Read latency: 0 cycles (combinational). Write latency: the value is visible from the register array on the cycle after the edge; the bypass path makes it visible in the same cycle.
- HAZARD is purely combinational from the current inputs and pending state. Decode holds the instruction and re-presents it each cycle until HAZARD is low.
- RESET asserted mid-operation clears pending state immediately, without waiting for an edge. In-flight results arriving after RESET deasserts are written normally.

## Structure
- Shared package/header `fpu_defs`: DATA_WIDTH/ADDR_WIDTH defaults and the FPU SELECT opcode constants. Decode uses those constants to derive ISSUE_WRITES and RSn_USED.
- Sub-module `fp_scoreboard`: pending vector, hazard logic and flush handling. The storage array and bypass muxes stay in `fp_reg_file`.

## Test plan
- Reset then read: assert RESET, read f0/f17/f31 → all 0x00000000, PENDING = 0, HAZARD = 0.
- Write/bypass: write f5 = 0x3F800000. In the same cycle READ_ADDR2 = 5 → READ_DATA2 = 0x3F800000. The next cycle, with WRITE_ENABLE = 0, READ_DATA1/2/3 all at address 5 → 0x3F800000.
- RAW stall: issue FMUL with dest f3 (accepted, PENDING[3] = 1). Next, issue FADD with RS1_USED and rs1 = 3 → HAZARD = 1 until a cycle with WRITE_ENABLE, WRITE_ADDR = 3. In that cycle HAZARD = 0 and READ_DATA1 = WRITE_DATA.
- WAW and simultaneous events: with f7 pending, issue dest 7 → HAZARD = 1. Then, in the same cycle, writeback f7 and issue dest 7 → HAZARD = 0 and PENDING[7] = 1 after the edge.
- FMADD rs3 hazard: f9 pending, RS3_USED with rs3 = 9 → HAZARD = 1. With RS3_USED = 0 and the same addresses → HAZARD = 0.
- Flush/reset mid-flight: f2 and f4 pending, then FLUSH with ISSUE_VALID for dest 6 → after the edge PENDING = 0 and f6 is not set. Pulse RESET asynchronously between edges with f8 pending → PENDING[8] clears immediately.

Source files
------------

// File: rtl/fpu_defs_pkg.sv
// Shared FPU definitions: default register-file geometry and the FPU SELECT opcodes
// that decode uses to work out destination writes and source usage.
package fpu_defs;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [4:0] {
    FPU_ADD     = 5'd0,
    FPU_SUB     = 5'd1,
    FPU_MUL     = 5'd2,
    FPU_DIV     = 5'd3,
    FPU_SQRT    = 5'd4,
    FPU_MADD    = 5'd5,
    FPU_MSUB    = 5'd6,
    FPU_NMADD   = 5'd7,
    FPU_NMSUB   = 5'd8,
    FPU_MIN     = 5'd9,
    FPU_MAX     = 5'd10,
    FPU_SGNJ    = 5'd11,
    FPU_SGNJN   = 5'd12,
    FPU_SGNJX   = 5'd13,
    FPU_EQ      = 5'd14,
    FPU_LT      = 5'd15,
    FPU_LE      = 5'd16,
    FPU_CVT_W_S = 5'd17,
    FPU_CVT_S_W = 5'd18,
    FPU_MV_X_W  = 5'd19,
    FPU_MV_W_X  = 5'd20,
    FPU_CLASS   = 5'd21,
    FPU_FLW     = 5'd22,
    FPU_FSW     = 5'd23
  } fpu_select_e;

  // Ops whose result lands in the integer file or memory leave the FP file untouched.
  function automatic logic fpu_writes_fp(input fpu_select_e op);
    case (op)
      FPU_EQ, FPU_LT, FPU_LE, FPU_CVT_W_S, FPU_MV_X_W, FPU_CLASS, FPU_FSW: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fp_reg_file_scoreboard.sv
// Issue scoreboard for the FP register file: one pending bit per register,
// RAW/WAW stall generation and flush handling.
module fp_scoreboard
  import fpu_defs::*;
#(
  parameter int ADDR_WIDTH = fpu_defs::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  input  logic [ADDR_WIDTH-1:0] read_addr3,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  rs3_used,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  issue_writes,
  input  logic                  flush,
  output logic                  hazard,
  output logic [DEPTH-1:0]      pending
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic [2:0]       src_hazard;
  logic             dest_hazard;
  logic             issue_accept;

  // A writeback landing this cycle resolves the hazard because the bypass supplies the value.
  always_comb begin
    src_hazard[0] = rs1_used && pending_q[read_addr1] && !(write_enable && write_addr == read_addr1);
    src_hazard[1] = rs2_used && pending_q[read_addr2] && !(write_enable && write_addr == read_addr2);
    src_hazard[2] = rs3_used && pending_q[read_addr3] && !(write_enable && write_addr == read_addr3);
    dest_hazard   = issue_writes && pending_q[issue_dest] && !(write_enable && write_addr == issue_dest);
    hazard        = issue_valid && !flush && ((|src_hazard) || dest_hazard);
    issue_accept  = issue_valid && !hazard && !flush && issue_writes;
  end

  // Later assignments win: flush over a new issue, a new issue over a same-address writeback.
  always_comb begin
    pending_d = pending_q;
    if (write_enable) pending_d[write_addr] = 1'b0;
    if (issue_accept) pending_d[issue_dest] = 1'b1;
    if (flush)        pending_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/fp_reg_file.sv
// FP architectural register file f0-f31 with three bypassed combinational read
// ports and an attached issue scoreboard.
module fp_reg_file
  import fpu_defs::*;
#(
  parameter int DATA_WIDTH = fpu_defs::DATA_WIDTH,
  parameter int ADDR_WIDTH = fpu_defs::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  input  logic [ADDR_WIDTH-1:0] read_addr3,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] read_data3,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  issue_writes,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  rs3_used,
  input  logic                  flush,
  output logic                  hazard,
  output logic [DEPTH-1:0]      pending
);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // f0 is an ordinary register here; a flush does not suppress the writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_enable) begin
      regs[write_addr] <= write_data;
    end
  end

  always_comb begin
    read_data1 = (write_enable && write_addr == read_addr1) ? write_data : regs[read_addr1];
    read_data2 = (write_enable && write_addr == read_addr2) ? write_data : regs[read_addr2];
    read_data3 = (write_enable && write_addr == read_addr3) ? write_data : regs[read_addr3];
  end

  fp_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .read_addr1  (read_addr1),
    .read_addr2  (read_addr2),
    .read_addr3  (read_addr3),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .rs3_used    (rs3_used),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_writes(issue_writes),
    .flush       (flush),
    .hazard      (hazard),
    .pending     (pending)
  );

endmodule

// File: tb/tb_fp_reg_file.sv
// Bench for fp_reg_file: directed hazard scenarios followed by random traffic,
// all checked against an array-based reference model.
module tb_fp_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  read_addr1 = '0, read_addr2 = '0, read_addr3 = '0;
  logic [31:0] read_data1, read_data2, read_data3;
  logic        write_enable = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dest = '0;
  logic        issue_writes = 1'b0;
  logic        rs1_used = 1'b0, rs2_used = 1'b0, rs3_used = 1'b0;
  logic        flush = 1'b0;
  logic        hazard;
  logic [31:0] pending;

  fp_reg_file dut (
    .clk(clk), .rst(rst),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_addr3(read_addr3),
    .read_data1(read_data1), .read_data2(read_data2), .read_data3(read_data3),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_writes(issue_writes),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rs3_used(rs3_used),
    .flush(flush), .hazard(hazard), .pending(pending)
  );

  always #5 clk = ~clk;

  int error_count = 0;
  int check_count = 0;

  // reference model: plain arrays of register values and pending flags
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  logic [31:0] last_rd1, last_rd2, last_rd3;
  logic        last_hazard;
  logic [31:0] last_pend;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (write_enable && write_addr == a) return write_data;
    return m_regs[a];
  endfunction

  function automatic bit model_blocked(input bit used, input logic [4:0] a);
    return used && m_pend[a] && !(write_enable && write_addr == a);
  endfunction

  function automatic bit model_hazard();
    bit any_src, dst;
    any_src = model_blocked(rs1_used, read_addr1) || model_blocked(rs2_used, read_addr2)
              || model_blocked(rs3_used, read_addr3);
    dst = model_blocked(issue_writes, issue_dest);
    return issue_valid && !flush && (any_src || dst);
  endfunction

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Drives one cycle of inputs, checks the combinational outputs mid-cycle,
  // then advances the model across the edge and checks the pending vector.
  task automatic applyStimulus(
    input bit we, input logic [4:0] wa, input logic [31:0] wd,
    input bit iv, input logic [4:0] id, input bit iw,
    input bit u1, input bit u2, input bit u3,
    input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
    input bit fl);
    bit exp_hz, accepted;
    @(negedge clk);
    write_enable = we; write_addr = wa; write_data = wd;
    issue_valid = iv; issue_dest = id; issue_writes = iw;
    rs1_used = u1; rs2_used = u2; rs3_used = u3;
    read_addr1 = a1; read_addr2 = a2; read_addr3 = a3;
    flush = fl;
    #1;
    exp_hz = model_hazard();
    last_rd1 = read_data1; last_rd2 = read_data2; last_rd3 = read_data3;
    last_hazard = hazard;
    checkOutput("read_data1", read_data1, model_read(a1));
    checkOutput("read_data2", read_data2, model_read(a2));
    checkOutput("read_data3", read_data3, model_read(a3));
    checkOutput("hazard", {31'b0, hazard}, {31'b0, exp_hz});
    accepted = iv && !exp_hz && !fl && iw;
    @(posedge clk);
    if (we) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (accepted) m_pend[id] = 1'b1;
    if (fl) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    #1;
    last_pend = pending;
    checkOutput("pending", pending, model_pend_vec());
  endtask

  initial begin
    model_reset();
    $display("[TB] reset and initial reads");
    #12;
    read_addr1 = 5'd0; read_addr2 = 5'd17; read_addr3 = 5'd31;
    #1;
    checkOutput("rst_rd_f0", read_data1, 32'h0);
    checkOutput("rst_rd_f17", read_data2, 32'h0);
    checkOutput("rst_rd_f31", read_data3, 32'h0);
    checkOutput("rst_pending", pending, 32'h0);
    checkOutput("rst_hazard", {31'b0, hazard}, 32'h0);
    rst = 1'b0;

    $display("[TB] write and bypass");
    applyStimulus(1, 5, 32'h3F800000, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    checkOutput("bypass_rd2", last_rd2, 32'h3F800000);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 0);
    checkOutput("stored_rd1", last_rd1, 32'h3F800000);
    checkOutput("stored_rd2", last_rd2, 32'h3F800000);
    checkOutput("stored_rd3", last_rd3, 32'h3F800000);

    $display("[TB] RAW stall");
    applyStimulus(0, 0, 32'h0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_pend3", {31'b0, last_pend[3]}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 10, 1, 1, 0, 0, 3, 0, 0, 0);
    checkOutput("raw_stall_a", {31'b0, last_hazard}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 10, 1, 1, 0, 0, 3, 0, 0, 0);
    checkOutput("raw_stall_b", {31'b0, last_hazard}, 32'h1);
    applyStimulus(1, 3, 32'h40490FDB, 1, 10, 1, 1, 0, 0, 3, 0, 0, 0);
    checkOutput("raw_release", {31'b0, last_hazard}, 32'h0);
    checkOutput("raw_bypass", last_rd1, 32'h40490FDB);

    $display("[TB] WAW and simultaneous events");
    applyStimulus(0, 0, 32'h0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_stall", {31'b0, last_hazard}, 32'h1);
    applyStimulus(1, 7, 32'h12345678, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_release", {31'b0, last_hazard}, 32'h0);
    checkOutput("waw_pend7", {31'b0, last_pend[7]}, 32'h1);

    $display("[TB] rs3 hazard");
    applyStimulus(0, 0, 32'h0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 11, 1, 0, 0, 1, 1, 2, 9, 0);
    checkOutput("rs3_stall", {31'b0, last_hazard}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 11, 1, 0, 0, 0, 1, 2, 9, 0);
    checkOutput("rs3_unused", {31'b0, last_hazard}, 32'h0);

    $display("[TB] flush and async reset");
    applyStimulus(0, 0, 32'h0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 12, 32'hCAFEF00D, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("flush_pending", last_pend, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0);
    checkOutput("flush_keeps_wb", last_rd1, 32'hCAFEF00D);
    applyStimulus(0, 0, 32'h0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pend8_set", {31'b0, last_pend[8]}, 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_pend8", {31'b0, pending[8]}, 32'h0);
    checkOutput("async_pending", pending, 32'h0);
    #1 rst = 1'b0;
    model_reset();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom(),
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 19) == 0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
